branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Parametrised successor to the ID-stage branch-condition logic of the 5-stage MIPS pipeline.
- Evaluates the full conditional-branch set in D.
- Holds a PC-indexed branch history table (BHT) of saturating counters. F looks it up to predict the branch direction.
- Flags mispredictions in D, trains the BHT on every resolved branch, and keeps branch and misprediction statistics counters.

Parameters:
- WIDTH, 32, data/PC width in bits (≥8).
- BHT_DEPTH, 64, number of BHT entries (power of 2, 2..1024).
- CTR_BITS, 2, width of each saturating counter (1..4).
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PcF  input  WIDTH  fetch PC for the BHT lookup.
- PredTakenF  output  1  prediction for PcF (combinational read).
- ValidD  input  1  instruction in D is valid (not a bubble).
- StallD  input  1  D stage stalled this cycle.
- OpD  input  6  opcode of the instruction in D.
- RtD  input  5  rt field of the instruction in D.
- RsDataD  input  WIDTH  forwarded rs value.
- RtDataD  input  WIDTH  forwarded rt value.
- PcD  input  WIDTH  PC of the instruction in D.
- PredTakenD  input  1  PredTakenF carried down the F/D register.
- IsBranchD  output  1  OpD/RtD decode to a supported branch.
- ConditionD  output  1  resolved direction (1 = taken).
- MispredictD  output  1  resolved direction differs from PredTakenD.
- BranchCount  output  STAT_BITS  resolved branches since reset.
- MispredCount  output  STAT_BITS  mispredictions since reset.

Behaviour:
- Decode (combinational):
  - 000100 beq: Rs==Rt.
  - 000101 bne: Rs!=Rt.
  - 000110 blez: signed Rs≤0.
  - 000111 bgtz: signed Rs>0.
  - 000001 with RtD=00000 bltz: Rs[WIDTH-1]=1.
  - 000001 with RtD=00001 bgez: Rs[WIDTH-1]=0.
  - 111111 bbt: RsDataD[RtD]==1. If RtD ≥ WIDTH, the condition is 0.
  - Any other encoding (including REGIMM with another RtD): IsBranchD=0 and ConditionD=0.
- Resolve event: Res = IsBranchD & ValidD & ~StallD.
- MispredictD = Res & (ConditionD != PredTakenD), combinational, same cycle as D. It is 0 whenever Res=0.
- BHT index: IDX = log2(BHT_DEPTH). Lookup uses PcF[IDX+1:2]; update uses PcD[IDX+1:2]. PC bits [1:0] are ignored.
- Prediction: PredTakenF = MSB of the indexed counter.
- Update on the edge where Res=1:
  - Taken: counter increments, saturating at all-ones.
  - Not taken: counter decrements, saturating at 0.
  - No update when Res=0. Only one entry changes per cycle.
- Read/write collision: when the lookup and update index match in the same cycle, PredTakenF shows the pre-update value. There is no bypass; the new value is visible the next cycle.
- Statistics, on the edge where Res=1:
  - BranchCount += 1.
  - MispredCount += 1 if MispredictD.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous, overrides all updates in that cycle):
  - Every BHT counter is set to weakly-not-taken: 0 followed by ones, i.e. 01 for CTR_BITS=2, 0 for CTR_BITS=1.
  - BranchCount=0 and MispredCount=0.
  - After reset, PredTakenF=0 for every PcF.
  - A reset asserted mid-run discards any pending update that cycle.
- Latency:
  - Decode, condition, misprediction and prediction outputs: 0 cycles (combinational).
  - BHT and statistics: visible 1 cycle after the resolving edge.
- Pure combinational outputs (IsBranchD, ConditionD, MispredictD) are not reset-gated. They follow their inputs even while reset is high.

Test Plan:
- Reset → PcF=0x0000_0040 gives PredTakenF=0; BranchCount=0 and MispredCount=0; every BHT entry reads weakly-not-taken.
- beq, Rs=Rt=0x1234, PredTakenD=0, PcD=0x40, ValidD=1, StallD=0:
  - Same cycle: ConditionD=1, MispredictD=1.
  - Next cycle: entry 16 = 10, PredTakenF(0x40)=1, BranchCount=1, MispredCount=1.
  - Repeat three more times: entry 16 saturates at 11. Four not-taken resolves then drive it to 00 and hold there.
- Signed decode with Rs=0xFFFF_FFFF:
  - blez → 1; bgtz → 0; bltz (RtD=0) → 1; bgez (RtD=1) → 0.
  - OpD=000001 with RtD=2 → IsBranchD=0.
  - Rs=0: blez=1, bgtz=0.
- bbt with Rs=0x0000_0100: RtD=8 → 1, RtD=7 → 0. With WIDTH=8, RtD=9 → 0.
- StallD=1 or ValidD=0 with a mispredicting beq:
  - MispredictD=0, BHT unchanged, counters unchanged.
  - Same-index collision (PcF=PcD=0x80) with a taken resolve: PredTakenF=0 this cycle, 1 the next.
- Reset asserted in the same cycle as a resolving taken branch → BHT and statistics counters all read reset values the next cycle. Preload BranchCount near all-ones (STAT_BITS=4, 16 resolves) → it holds at 0xF.

Source files
------------

// File: rtl/branch_unit.sv
// D-stage branch condition resolve, PC-indexed saturating-counter BHT predictor
// for F, and branch/misprediction statistics counters.
module branch_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     PcF,
  output logic                 PredTakenF,
  input  logic                 ValidD,
  input  logic                 StallD,
  input  logic [5:0]           OpD,
  input  logic [4:0]           RtD,
  input  logic [WIDTH-1:0]     RsDataD,
  input  logic [WIDTH-1:0]     RtDataD,
  input  logic [WIDTH-1:0]     PcD,
  input  logic                 PredTakenD,
  output logic                 IsBranchD,
  output logic                 ConditionD,
  output logic                 MispredictD,
  output logic [STAT_BITS-1:0] BranchCount,
  output logic [STAT_BITS-1:0] MispredCount
);

  localparam int unsigned IDX = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_BBT    = 6'b111111;

  logic [CTR_BITS-1:0]  bht_q [BHT_DEPTH];
  logic [CTR_BITS-1:0]  bht_d;
  logic [STAT_BITS-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_BITS-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [IDX-1:0]       lu_idx, upd_idx;
  logic [WIDTH-1:0]     bbt_shift;
  logic                 rs_neg, rs_zero, res;
  logic                 unused_pc;

  // PC bits outside the index field are intentionally ignored
  assign unused_pc = ^{PcF, PcD};
  assign lu_idx    = IDX'(PcF >> 2);
  assign upd_idx   = IDX'(PcD >> 2);

  assign rs_neg    = RsDataD[WIDTH-1];
  assign rs_zero   = (RsDataD == '0);
  // Shift-out yields 0 for any bit position at or beyond WIDTH
  assign bbt_shift = RsDataD >> RtD;

  always_comb begin
    IsBranchD  = 1'b0;
    ConditionD = 1'b0;
    unique case (OpD)
      OP_BEQ:  begin IsBranchD = 1'b1; ConditionD = (RsDataD == RtDataD); end
      OP_BNE:  begin IsBranchD = 1'b1; ConditionD = (RsDataD != RtDataD); end
      OP_BLEZ: begin IsBranchD = 1'b1; ConditionD = rs_neg | rs_zero; end
      OP_BGTZ: begin IsBranchD = 1'b1; ConditionD = ~rs_neg & ~rs_zero; end
      OP_BBT:  begin IsBranchD = 1'b1; ConditionD = bbt_shift[0]; end
      OP_REGIMM: begin
        if (RtD == 5'd0) begin
          IsBranchD  = 1'b1;
          ConditionD = rs_neg;
        end else if (RtD == 5'd1) begin
          IsBranchD  = 1'b1;
          ConditionD = ~rs_neg;
        end
      end
      default: ;
    endcase
  end

  assign res         = IsBranchD & ValidD & ~StallD;
  assign MispredictD = res & (ConditionD != PredTakenD);
  assign PredTakenF  = bht_q[lu_idx][CTR_BITS-1];

  // Next counter value for the resolving entry, saturating both ways
  always_comb begin
    bht_d = bht_q[upd_idx];
    if (ConditionD) begin
      if (bht_q[upd_idx] != CTR_MAX) bht_d = bht_q[upd_idx] + CTR_BITS'(1);
    end else begin
      if (bht_q[upd_idx] != '0) bht_d = bht_q[upd_idx] - CTR_BITS'(1);
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res && branch_cnt_q != STAT_MAX) branch_cnt_d = branch_cnt_q + STAT_BITS'(1);
    if (MispredictD && mispred_cnt_q != STAT_MAX) mispred_cnt_d = mispred_cnt_q + STAT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= CTR_WNT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (res) bht_q[upd_idx] <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Randomized + directed bench for branch_unit against a behavioural model
// (decode by signed arithmetic, BHT as an int array, saturating statistics).
module tb_branch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters
  logic        reset, ValidD, StallD, PredTakenD;
  logic [5:0]  OpD;
  logic [4:0]  RtD;
  logic [31:0] PcF, RsDataD, RtDataD, PcD;
  logic        PredTakenF, IsBranchD, ConditionD, MispredictD;
  logic [31:0] BranchCount, MispredCount;

  branch_unit u_dut (
    .clk(clk), .reset(reset), .PcF(PcF), .PredTakenF(PredTakenF),
    .ValidD(ValidD), .StallD(StallD), .OpD(OpD), .RtD(RtD),
    .RsDataD(RsDataD), .RtDataD(RtDataD), .PcD(PcD), .PredTakenD(PredTakenD),
    .IsBranchD(IsBranchD), .ConditionD(ConditionD), .MispredictD(MispredictD),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  // Small instance: narrow data and statistics for boundary cases
  logic       s_reset, s_ValidD, s_StallD, s_PredTakenD;
  logic [5:0] s_OpD;
  logic [4:0] s_RtD;
  logic [7:0] s_PcF, s_RsDataD, s_RtDataD, s_PcD;
  logic       s_PredTakenF, s_IsBranchD, s_ConditionD, s_MispredictD;
  logic [3:0] s_BranchCount, s_MispredCount;

  branch_unit #(.WIDTH(8), .BHT_DEPTH(16), .CTR_BITS(2), .STAT_BITS(4)) u_small (
    .clk(clk), .reset(s_reset), .PcF(s_PcF), .PredTakenF(s_PredTakenF),
    .ValidD(s_ValidD), .StallD(s_StallD), .OpD(s_OpD), .RtD(s_RtD),
    .RsDataD(s_RsDataD), .RtDataD(s_RtDataD), .PcD(s_PcD), .PredTakenD(s_PredTakenD),
    .IsBranchD(s_IsBranchD), .ConditionD(s_ConditionD), .MispredictD(s_MispredictD),
    .BranchCount(s_BranchCount), .MispredCount(s_MispredCount)
  );

  int total = 0;
  int bad   = 0;

  // Reference state
  int     m_bht [64];
  longint m_bc, m_mc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_dec(input logic [5:0] op, input logic [4:0] rt,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output bit isb, output bit cnd);
    int sa;
    sa  = $signed(a);
    isb = 1'b1;
    cnd = 1'b0;
    case (op)
      6'd4:  cnd = (a == b);
      6'd5:  cnd = (a != b);
      6'd6:  cnd = (sa <= 0);
      6'd7:  cnd = (sa > 0);
      6'd1: begin
        if (rt == 5'd0)      cnd = (sa < 0);
        else if (rt == 5'd1) cnd = (sa >= 0);
        else                 isb = 1'b0;
      end
      6'd63: cnd = a[rt];
      default: isb = 1'b0;
    endcase
  endfunction

  function automatic int pidx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[pidx(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  // Drive one D-stage cycle, check combinational outputs, clock, check stats
  task automatic cyc(input logic rst, input logic v, input logic st,
                     input logic [5:0] op, input logic [4:0] rt,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pcd, input logic [31:0] pcf, input logic pt);
    bit isb, cnd, res, mis;
    reset = rst; ValidD = v; StallD = st; OpD = op; RtD = rt;
    RsDataD = a; RtDataD = b; PcD = pcd; PcF = pcf; PredTakenD = pt;
    #1;
    ref_dec(op, rt, a, b, isb, cnd);
    res = isb & v & ~st;
    mis = res & (cnd != pt);
    check_eq("is_branch", 32'(IsBranchD), 32'(isb));
    check_eq("condition", 32'(ConditionD), 32'(cnd));
    check_eq("mispredict", 32'(MispredictD), 32'(mis));
    check_eq("pred_f", 32'(PredTakenF), 32'(m_pred(pcf)));
    if (rst) model_reset();
    else if (res) begin
      if (cnd) m_bht[pidx(pcd)] = (m_bht[pidx(pcd)] < 3) ? m_bht[pidx(pcd)] + 1 : 3;
      else     m_bht[pidx(pcd)] = (m_bht[pidx(pcd)] > 0) ? m_bht[pidx(pcd)] - 1 : 0;
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (mis && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
    @(posedge clk);
    #1;
    check_eq("branch_cnt", BranchCount, 32'(m_bc));
    check_eq("mispred_cnt", MispredCount, 32'(m_mc));
  endtask

  task automatic idle(input logic [31:0] pcf);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, pcf, 1'b0);
  endtask

  initial begin
    logic [5:0]  ops [7];
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b, pcd, pcf;
    ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd6; ops[3] = 6'd7;
    ops[4] = 6'd1; ops[5] = 6'd63; ops[6] = 6'd0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_bc = 0; m_mc = 0;
    reset = 1'b1; ValidD = 0; StallD = 0; OpD = 0; RtD = 0;
    RsDataD = 0; RtDataD = 0; PcD = 0; PcF = 0; PredTakenD = 0;
    s_reset = 1'b1; s_ValidD = 0; s_StallD = 0; s_OpD = 0; s_RtD = 0;
    s_RsDataD = 0; s_RtDataD = 0; s_PcD = 0; s_PcF = 0; s_PredTakenD = 0;
    @(posedge clk); #1;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0);
    reset = 1'b0;
    check_eq("rst_pred_40", 32'(PredTakenF), 32'd0);
    for (int i = 0; i < 64; i++) begin
      PcF = 32'(i * 4);
      #0.1;
      check_eq("rst_bht_entry", 32'(PredTakenF), 32'd0);
    end
    @(posedge clk); #1;

    // Taken beq trains entry 16 up, then not-taken drives it down
    cyc(1'b0, 1'b1, 1'b0, 6'd4, 5'd0, 32'h1234, 32'h1234, 32'h40, 32'h40, 1'b0);
    check_eq("beq_pred_after", 32'(PredTakenF), 32'd1);
    check_eq("beq_bcnt_1", BranchCount, 32'd1);
    check_eq("beq_mcnt_1", MispredCount, 32'd1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b0, 6'd4, 5'd0, 32'h1234, 32'h1234, 32'h40, 32'h40, m_pred(32'h40));
    check_eq("bht16_sat_hi", 32'(m_bht[16]), 32'd3);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b0, 6'd4, 5'd0, 32'h1234, 32'h1235, 32'h40, 32'h40, m_pred(32'h40));
    check_eq("bht16_pred_lo", 32'(PredTakenF), 32'd0);

    // Signed decode corners
    cyc(1'b0, 1'b0, 1'b0, 6'd6, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd7, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd1, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd1, 5'd1, 32'hFFFF_FFFF, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 6'd1, 5'd2, 32'hFFFF_FFFF, 32'd0, 32'h44, 32'h44, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 6'd6, 5'd0, 32'd0, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd7, 5'd0, 32'd0, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd63, 5'd8, 32'h100, 32'd0, 32'h44, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd63, 5'd7, 32'h100, 32'd0, 32'h44, 32'h44, 1'b0);

    // Stalled / invalid mispredicting beq must not resolve
    cyc(1'b0, 1'b1, 1'b1, 6'd4, 5'd0, 32'h5, 32'h5, 32'h48, 32'h48, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 6'd4, 5'd0, 32'h5, 32'h5, 32'h48, 32'h48, 1'b0);

    // Same-index collision: no bypass
    cyc(1'b0, 1'b1, 1'b0, 6'd4, 5'd0, 32'h7, 32'h7, 32'h80, 32'h80, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 6'd4, 5'd0, 32'h7, 32'h7, 32'h80, 32'h80, 1'b0);
    check_eq("collide_next", 32'(PredTakenF), 32'd1);

    // Reset wins over a resolving taken branch
    cyc(1'b1, 1'b1, 1'b0, 6'd4, 5'd0, 32'h9, 32'h9, 32'h80, 32'h80, 1'b0);
    check_eq("rst_win_pred", 32'(PredTakenF), 32'd0);
    check_eq("rst_win_bcnt", BranchCount, 32'd0);

    // Randomized traffic with occasional mid-run reset
    for (int n = 0; n < 500; n++) begin
      op  = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      rt  = (op == 6'd1) ? 5'($urandom_range(0, 2)) : 5'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a = {{28{a[31]}}, a[3:0]};
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      pcd = 32'($urandom_range(0, 15) * 4 + 32'h100);
      pcf = ($urandom_range(0, 3) == 0) ? pcd : 32'($urandom_range(0, 15) * 4 + 32'h100);
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
          op, rt, a, b, pcd, pcf,
          ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_pred(pcd));
    end
    idle(32'h0);

    // Narrow instance: bbt out of range and statistics saturation
    s_reset = 1'b1;
    @(posedge clk); #1;
    s_reset = 1'b0;
    check_eq("s_rst_bcnt", 32'(s_BranchCount), 32'd0);
    s_OpD = 6'd63; s_RsDataD = 8'hFF; s_RtD = 5'd9;
    #1;
    check_eq("s_bbt_rt9", 32'(s_ConditionD), 32'd0);
    s_RtD = 5'd7;
    #1;
    check_eq("s_bbt_rt7", 32'(s_ConditionD), 32'd1);
    s_OpD = 6'd4; s_RsDataD = 8'h12; s_RtDataD = 8'h12; s_PredTakenD = 1'b0;
    s_PcD = 8'h40; s_PcF = 8'h40; s_ValidD = 1'b1;
    @(posedge clk); #1;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      check_eq("s_bcnt_sat", 32'(s_BranchCount), (n > 15) ? 32'd15 : 32'(n));
      check_eq("s_mcnt_sat", 32'(s_MispredCount), (n > 15) ? 32'd15 : 32'(n));
    end
    s_ValidD = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
